// File: rtl/clk_en_gen.sv
// clk_en_gen: single-cycle clock-enable strobe every div_q+1 cycles of clk,
// with run/stop control and a divisor update that only lands at a wrap.
// Optional square-wave output is built when CLK_EN_GEN_SQUARE_EN is defined.
module clk_en_gen #(
  parameter int WIDTH       = 4,
  parameter int DEFAULT_DIV = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  output logic             clk_en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] div_q,
  output logic             pend,
  output logic             clk_sq
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  // State registers
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_div_q;
  logic [WIDTH-1:0] r_pdiv;
  logic             r_pend;
  logic             r_clk_en;

  // Next-state values
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_div_nxt;
  logic [WIDTH-1:0] w_pdiv_nxt;
  logic             w_pend_nxt;
  logic             w_en_nxt;
  logic             w_term;

  // Terminal count: counter has reached the divisor in effect.
  assign w_term = (r_count == r_div_q);

  // Next-state: stop clears and applies any divisor; a wrap fires the strobe and
  // swaps in a coincident load (preferred) or the pending one; mid-period loads
  // are parked until the wrap so the running period finishes on the old divisor.
  always_comb begin
    w_count_nxt = r_count;
    w_div_nxt   = r_div_q;
    w_pdiv_nxt  = r_pdiv;
    w_pend_nxt  = r_pend;
    w_en_nxt    = 1'b0;
    if (!run) begin
      w_count_nxt = '0;
      w_pend_nxt  = 1'b0;
      if (load) begin
        w_div_nxt = div_in;
      end else if (r_pend) begin
        w_div_nxt = r_pdiv;
      end
    end else if (w_term) begin
      w_count_nxt = '0;
      w_en_nxt    = 1'b1;
      w_pend_nxt  = 1'b0;
      if (load) begin
        w_div_nxt = div_in;
      end else if (r_pend) begin
        w_div_nxt = r_pdiv;
      end
    end else begin
      w_count_nxt = r_count + ONE;
      if (load) begin
        w_pdiv_nxt = div_in;
        w_pend_nxt = 1'b1;
      end
    end
  end

  // Register update with asynchronous reset to the default divisor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_div_q  <= DEF_DIV;
      r_pdiv   <= '0;
      r_pend   <= 1'b0;
      r_clk_en <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_div_q  <= w_div_nxt;
      r_pdiv   <= w_pdiv_nxt;
      r_pend   <= w_pend_nxt;
      r_clk_en <= w_en_nxt;
    end
  end

`ifdef CLK_EN_GEN_SQUARE_EN
  logic r_clk_sq;

  // Square wave: flips on every strobe, forced low while stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sq <= 1'b0;
    end else if (!run) begin
      r_clk_sq <= 1'b0;
    end else if (w_en_nxt) begin
      r_clk_sq <= ~r_clk_sq;
    end
  end

  assign clk_sq = r_clk_sq;
`else
  assign clk_sq = 1'b0;
`endif

  assign clk_en = r_clk_en;
  assign count  = r_count;
  assign div_q  = r_div_q;
  assign pend   = r_pend;

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen with default parameters (WIDTH=4, DEFAULT_DIV=15).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_clk_en_gen;

  logic       clk;
  logic       rst;
  logic       run;
  logic       load;
  logic [3:0] div_in;
  logic       clk_en;
  logic [3:0] count;
  logic [3:0] div_q;
  logic       pend;
  logic       clk_sq;

  int n_cmp;
  int n_err;

`ifdef CLK_EN_GEN_SQUARE_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  clk_en_gen #(.WIDTH(4), .DEFAULT_DIV(15)) dut (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .load   (load),
    .div_in (div_in),
    .clk_en (clk_en),
    .count  (count),
    .div_q  (div_q),
    .pend   (pend),
    .clk_sq (clk_sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One rising edge, then settle to the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b1;
    run    = 1'b0;
    load   = 1'b0;
    div_in = 4'd0;
    @(negedge clk);

    // Reset values
    chk("rst_count", count, 0);
    chk("rst_div", div_q, 15);
    chk("rst_en", clk_en, 0);
    chk("rst_pend", pend, 0);
    chk("rst_sq", clk_sq, 0);

    // Defaults: strobes at edges 16, 32, 48
    rst = 1'b0;
    run = 1'b1;
    for (int n = 1; n <= 48; n++) begin
      step();
      chk("def_en", clk_en, (n % 16 == 0) ? 1 : 0);
      chk("def_count", count, n % 16);
    end
    chk("def_div", div_q, 15);

    // Load 3 at count 5: pending until wrap, then period 4
    for (int n = 1; n <= 5; n++) step();
    chk("ld_pre_count", count, 5);
    load = 1'b1; div_in = 4'd3;
    step();
    load = 1'b0;
    chk("ld_pend_set", pend, 1);
    chk("ld_div_old", div_q, 15);
    for (int k = 7; k <= 16; k++) begin
      step();
      chk("ld_pend", pend, (k < 16) ? 1 : 0);
      chk("ld_count", count, k % 16);
      chk("ld_en", clk_en, (k == 16) ? 1 : 0);
    end
    chk("ld_div_new", div_q, 3);
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("p4_en", clk_en, (j % 4 == 0) ? 1 : 0);
      chk("p4_count", count, j % 4);
    end

    // Stop, load 0 while stopped, run: strobe every cycle, stop drops it
    run = 1'b0;
    step();
    chk("stop_count", count, 0);
    chk("stop_en", clk_en, 0);
    load = 1'b1; div_in = 4'd0;
    step();
    load = 1'b0;
    chk("stop_ld_div", div_q, 0);
    chk("stop_ld_pend", pend, 0);
    run = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      step();
      chk("d0_en", clk_en, 1);
      chk("d0_count", count, 0);
    end
    run = 1'b0;
    step();
    chk("d0_stop_en", clk_en, 0);

    // Load coincident with terminal count: applied directly, pend stays low
    load = 1'b1; div_in = 4'd3;
    step();
    load = 1'b0;
    run  = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      step();
      chk("tc_count", count, j);
    end
    load = 1'b1; div_in = 4'd7;
    step();
    load = 1'b0;
    chk("tc_en", clk_en, 1);
    chk("tc_div", div_q, 7);
    chk("tc_pend", pend, 0);
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("p8_en", clk_en, (j == 8) ? 1 : 0);
      chk("p8_pend", pend, 0);
      chk("p8_count", count, j % 8);
    end

    // Back-to-back loads 5 then 2: last one wins at the wrap
    step();
    step();
    load = 1'b1; div_in = 4'd5;
    step();
    chk("bb_pend1", pend, 1);
    div_in = 4'd2;
    step();
    load = 1'b0;
    chk("bb_pend2", pend, 1);
    chk("bb_div_old", div_q, 7);
    for (int k = 5; k <= 8; k++) begin
      step();
      chk("bb_en", clk_en, (k == 8) ? 1 : 0);
    end
    chk("bb_div", div_q, 2);
    chk("bb_pend_clr", pend, 0);
    for (int j = 1; j <= 3; j++) begin
      step();
      chk("p3_en", clk_en, (j == 3) ? 1 : 0);
      chk("p3_count", count, j % 3);
    end

    // Asynchronous reset at count 9 with a pending load
    run = 1'b0;
    step();
    load = 1'b1; div_in = 4'd12;
    step();
    load = 1'b0;
    chk("ar_div12", div_q, 12);
    run = 1'b1;
    for (int j = 1; j <= 8; j++) step();
    load = 1'b1; div_in = 4'd4;
    step();
    load = 1'b0;
    chk("ar_count9", count, 9);
    chk("ar_pend_pre", pend, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_count", count, 0);
    chk("ar_en", clk_en, 0);
    chk("ar_div", div_q, 15);
    chk("ar_pend", pend, 0);
    chk("ar_sq", clk_sq, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      step();
      chk("ar_rel_en", clk_en, (j == 16) ? 1 : 0);
      chk("ar_rel_count", count, j % 16);
    end

    // Square wave with divisor 3 (constant 0 when the option is not built)
    run = 1'b0;
    step();
    load = 1'b1; div_in = 4'd3;
    step();
    load = 1'b0;
    run  = 1'b1;
    for (int j = 1; j <= 14; j++) begin
      step();
      chk("sq_en", clk_en, (j % 4 == 0) ? 1 : 0);
      chk("sq_val", clk_sq, SQ ? ((j / 4) % 2) : 0);
    end
    run = 1'b0;
    step();
    chk("sq_stop", clk_sq, 0);
    chk("sq_stop_en", clk_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
